// File: rtl/window_kernel_mac.sv
// Pipelined 2-D kernel multiply-accumulate with a double-buffered, frame-synchronous kernel bank.
// Define WINDOW_KERNEL_MAC_SAT_EN to clamp results (sat_o active); otherwise results wrap.
module window_kernel_mac #(
  parameter int DATA_WIDTH    = 8,
  parameter int WINDOW_WIDTH  = 5,
  parameter int WINDOW_HEIGHT = 5,
  parameter int COEFF_WIDTH   = 8,
  parameter int SHIFT         = 4,
  parameter int OUT_WIDTH     = 8,
  parameter int COORD_WIDTH   = 16,
  localparam int N            = WINDOW_WIDTH * WINDOW_HEIGHT,
  localparam int CAW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N*DATA_WIDTH-1:0]  window_i,
  input  logic [COORD_WIDTH-1:0]   col_i,
  input  logic [COORD_WIDTH-1:0]   row_i,
  input  logic                     valid_i,
  input  logic                     coeff_we_i,
  input  logic [CAW-1:0]           coeff_addr_i,
  input  logic [COEFF_WIDTH-1:0]   coeff_data_i,
  input  logic                     coeff_commit_i,
  output logic [OUT_WIDTH-1:0]     pixel_o,
  output logic [COORD_WIDTH-1:0]   col_o,
  output logic [COORD_WIDTH-1:0]   row_o,
  output logic                     valid_o,
  output logic                     sat_o,
  output logic                     coeff_pending_o
);

  localparam int L2     = $clog2(N);
  localparam int PW     = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int ACC_W  = PW + L2;
  localparam int AW1    = ACC_W + 1;
  localparam int DEPTH  = L2 + 3;
  localparam int CENTER = ((WINDOW_HEIGHT - 1) / 2) * WINDOW_WIDTH + (WINDOW_WIDTH - 1) / 2;
  localparam logic signed [COEFF_WIDTH-1:0] IDENT_TAP = COEFF_WIDTH'(1 << SHIFT);
  localparam logic signed [AW1-1:0]         ROUND     = AW1'((1 << SHIFT) >> 1);

  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

  function automatic int levelCount(input int lvl);
    int c;
    c = N;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Keeps tree operand indices inside the array on branches the level count never takes.
  function automatic int clampIdx(input int i);
    return (i < N) ? i : N - 1;
  endfunction

  coeff_t                         r_shadow     [N];
  coeff_t                         r_staged     [N];
  coeff_t                         r_active     [N];
  coeff_t                         w_shadowNext [N];
  logic                           r_pending;
  logic                           w_frameStart;

  logic [N*DATA_WIDTH-1:0]        r_win;
  logic signed [ACC_W-1:0]        r_tree [L2+1][N];
  logic [DEPTH-1:0]               r_vPipe;
  logic [COORD_WIDTH-1:0]         r_colPipe [DEPTH];
  logic [COORD_WIDTH-1:0]         r_rowPipe [DEPTH];
  logic [OUT_WIDTH-1:0]           r_pixel;
  logic                           r_sat;

  logic signed [AW1-1:0]          w_rounded;
  logic signed [AW1-1:0]          w_shifted;
  logic [OUT_WIDTH-1:0]           w_pixelNext;
  logic                           w_satNext;

  assign w_frameStart = valid_i && (col_i == '0) && (row_i == '0);

  always_comb begin
    w_shadowNext = r_shadow;
    if (coeff_we_i && (int'(coeff_addr_i) < N)) w_shadowNext[coeff_addr_i] = coeff_data_i;
  end

  // A commit snapshots the shadow bank; the snapshot is promoted when the next frame starts.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < N; k++) begin
        r_shadow[k] <= (k == CENTER) ? IDENT_TAP : '0;
        r_staged[k] <= (k == CENTER) ? IDENT_TAP : '0;
        r_active[k] <= (k == CENTER) ? IDENT_TAP : '0;
      end
      r_pending <= 1'b0;
    end else begin
      r_shadow <= w_shadowNext;
      if (coeff_commit_i) r_staged <= w_shadowNext;
      if (w_frameStart && coeff_commit_i) r_active <= w_shadowNext;
      else if (w_frameStart && r_pending) r_active <= r_staged;
      r_pending <= !w_frameStart && (r_pending || coeff_commit_i);
    end
  end

  always_ff @(posedge clk_i) begin
    r_win <= window_i;
    for (int k = 0; k < N; k++) begin
      r_tree[0][k] <= ACC_W'(
        $signed({{(COEFF_WIDTH+1){1'b0}}, r_win[k*DATA_WIDTH +: DATA_WIDTH]}) *
        $signed({{(DATA_WIDTH+1){r_active[k][COEFF_WIDTH-1]}}, r_active[k]}));
    end
    for (int l = 1; l <= L2; l++) begin
      for (int j = 0; j < N; j++) begin
        if (2*j + 1 < levelCount(l - 1))
          r_tree[l][j] <= r_tree[l-1][clampIdx(2*j)] + r_tree[l-1][clampIdx(2*j + 1)];
        else if (2*j < levelCount(l - 1))
          r_tree[l][j] <= r_tree[l-1][clampIdx(2*j)];
        else
          r_tree[l][j] <= '0;
      end
    end
  end

  assign w_rounded = $signed({r_tree[L2][0][ACC_W-1], r_tree[L2][0]}) + ROUND;
  assign w_shifted = w_rounded >>> SHIFT;

`ifdef WINDOW_KERNEL_MAC_SAT_EN
  localparam logic signed [AW1-1:0] PIX_MAX = AW1'((1 << OUT_WIDTH) - 1);

  always_comb begin
    w_pixelNext = OUT_WIDTH'(w_shifted);
    w_satNext   = 1'b0;
    if (w_shifted < 0) begin
      w_pixelNext = '0;
      w_satNext   = 1'b1;
    end else if (w_shifted > PIX_MAX) begin
      w_pixelNext = '1;
      w_satNext   = 1'b1;
    end
  end
`else
  always_comb begin
    w_pixelNext = OUT_WIDTH'(w_shifted);
    w_satNext   = 1'b0;
  end
`endif

  // Tags and valid travel one register per data stage so they line up with r_pixel.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_vPipe <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        r_colPipe[d] <= '0;
        r_rowPipe[d] <= '0;
      end
      r_pixel <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_vPipe      <= {r_vPipe[DEPTH-2:0], valid_i};
      r_colPipe[0] <= col_i;
      r_rowPipe[0] <= row_i;
      for (int d = 1; d < DEPTH; d++) begin
        r_colPipe[d] <= r_colPipe[d-1];
        r_rowPipe[d] <= r_rowPipe[d-1];
      end
      r_pixel <= w_pixelNext;
      r_sat   <= w_satNext && r_vPipe[DEPTH-2];
    end
  end

  assign pixel_o         = r_pixel;
  assign sat_o           = r_sat;
  assign valid_o         = r_vPipe[DEPTH-1];
  assign col_o           = r_colPipe[DEPTH-1];
  assign row_o           = r_rowPipe[DEPTH-1];
  assign coeff_pending_o = r_pending;

endmodule
